// File: rtl/msx_config_parser_pkg.sv
// Shared MSX configuration types: record/type enums, the decoded record
// struct handed from the byte collector to the parser, parser states and
// error codes.
package msx_config_parser_pkg;

    // Configuration record types carried in b0[7:4].
    typedef enum logic [3:0] {
        CONFIG_NONE          = 4'd0,
        CONFIG_FDC           = 4'd1,
        CONFIG_SLOT_A        = 4'd2,
        CONFIG_SLOT_B        = 4'd3,
        CONFIG_SLOT_INTERNAL = 4'd4,
        CONFIG_KBD_LAYOUT    = 4'd5,
        CONFIG_CONFIG        = 4'd6
    } config_typ_t;

    typedef enum logic [3:0] {
        MAPPER_NONE       = 4'd0,
        MAPPER_ASCII8     = 4'd1,
        MAPPER_ASCII16    = 4'd2,
        MAPPER_KONAMI     = 4'd3,
        MAPPER_KONAMI_SCC = 4'd4,
        MAPPER_GM2        = 4'd5,
        MAPPER_LINEAR     = 4'd6,
        MAPPER_RAM        = 4'd7,
        MAPPER_AUTO       = 4'd15
    } mapper_typ_t;

    typedef enum logic [3:0] {
        DEVICE_NONE = 4'd0,
        DEVICE_FDC  = 4'd1,
        DEVICE_OPL3 = 4'd2,
        DEVICE_SCC  = 4'd3
    } device_typ_t;

    // Data identifier; zero marks a mirror of the previous data record.
    typedef logic [7:0] data_ID_t;
    localparam data_ID_t DATA_MIRROR = 8'h00;

    typedef struct packed {
        config_typ_t typ;
        logic [1:0]  slot;
        logic [1:0]  sub;
        data_ID_t    data_id;
        logic [7:0]  count;
        logic [7:0]  start_page;
        mapper_typ_t mapper;
        device_typ_t device;
    } config_record_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_TYPE   = 2'd1,
        ERR_RANGE      = 2'd2,
        ERR_TRUNC_REFS = 2'd3
    } parser_err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECODE,
        ST_EMIT,
        ST_DONE
    } parser_state_t;

    // Record types that expand into block-table writes.
    function automatic logic is_table_write(input config_typ_t t);
        return (t == CONFIG_SLOT_A) || (t == CONFIG_SLOT_B) ||
               (t == CONFIG_SLOT_INTERNAL);
    endfunction

endpackage

// File: rtl/msx_config_record_buf.sv
// Byte collector for one configuration record.
//   clk, reset_n   : clock, async active-low reset
//   clear_i        : drop any partial record and restart at byte 0
//   accept_i       : data_i is consumed this cycle
//   data_i         : record byte
//   rec_o          : decoded b0..b6 fields of the stored record
//   rec_valid_o    : final byte of a record accepted this cycle
//   last_byte_o    : next accepted byte is the record's final byte
module msx_config_record_buf
    import msx_config_parser_pkg::*;
#(
    parameter int RECORD_BYTES = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear_i,
    input  logic           accept_i,
    input  logic [7:0]     data_i,
    output config_record_t rec_o,
    output logic           rec_valid_o,
    output logic           last_byte_o
);

    localparam int CW = $clog2(RECORD_BYTES);

    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    b0_q, b1_q, b3_q, b4_q;
    logic [3:0]    b5_q, b6_q;

    assign last_byte_o = (byte_cnt_q == CW'(RECORD_BYTES - 1));
    assign rec_valid_o = accept_i && last_byte_o;

    // NOTE: every always_comb assigns its outputs a default first so no
    // path leaves a value held, which would infer a latch.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (clear_i) begin
            byte_cnt_d = '0;
        end else if (accept_i) begin
            byte_cnt_d = last_byte_o ? '0 : byte_cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // NOTE: the field bytes carry no reset; they are only read after all
    // of them have been rewritten by a complete record.
    always_ff @(posedge clk) begin
        if (accept_i) begin
            case (byte_cnt_q)
                CW'(0):  b0_q <= data_i;
                CW'(1):  b1_q <= data_i;
                CW'(3):  b3_q <= data_i;
                CW'(4):  b4_q <= data_i;
                CW'(5):  b5_q <= data_i[3:0];
                CW'(6):  b6_q <= data_i[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rec_o            = '0;
        rec_o.typ        = config_typ_t'(b0_q[7:4]);
        rec_o.slot       = b0_q[3:2];
        rec_o.sub        = b0_q[1:0];
        rec_o.data_id    = b1_q;
        rec_o.count      = b3_q;
        rec_o.start_page = b4_q;
        rec_o.mapper     = mapper_typ_t'(b5_q);
        rec_o.device     = device_typ_t'(b6_q);
    end

endmodule

// File: rtl/msx_config_parser.sv
// Streaming parser for the MSX machine-configuration image. Collects
// fixed-length records, decodes them and expands slot records into
// per-page block-table writes; tracks data references for mirrors, and
// derives expander enables and the MSX type.
//   start, in_valid/in_data/in_last/in_ready : image download handshake
//   blk_*        : registered block-table write, fields valid with blk_we
//   expander_en  : per-slot expander enable
//   msx_typ      : MSX type from the CONFIG record
//   busy/done/error/err_code : parse status (done, error sticky)
module msx_config_parser
    import msx_config_parser_pkg::*;
#(
    parameter  int RECORD_BYTES = 12,
    parameter  int MAX_REFS     = 16,
    parameter  int PAGES        = 4,
    localparam int REF_W        = $clog2(MAX_REFS),
    localparam int PW           = $clog2(PAGES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             blk_we,
    output logic [1:0]       blk_slot,
    output logic [1:0]       blk_sub,
    output logic [PW-1:0]    blk_page,
    output logic [REF_W-1:0] blk_ref,
    output logic [PW-1:0]    blk_offset,
    output logic [3:0]       blk_mapper,
    output logic [3:0]       blk_device,
    output logic             blk_cart,
    output logic [3:0]       expander_en,
    output logic             msx_typ,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    parser_state_t  state_q, state_d;
    config_record_t rec;
    logic           rec_valid, last_byte, accept, trunc, is_mirror, emit_last;
    parser_err_t    dec_err, err_now;
    logic           dec_emit;

    logic [REF_W:0]   ref_cnt_q;
    logic             have_ref_q, cur_mirror_q, last_seen_q;
    logic [REF_W-1:0] cur_ref_q;
    logic [PW-1:0]    page_q;
    logic             done_q, error_q, msx_typ_q;
    logic [1:0]       err_code_q;
    logic [3:0]       expander_q;

    logic             blk_we_d, blk_we_q, blk_cart_d, blk_cart_q;
    logic [1:0]       blk_slot_d, blk_slot_q, blk_sub_d, blk_sub_q;
    logic [PW-1:0]    blk_page_d, blk_page_q, blk_offset_d, blk_offset_q;
    logic [REF_W-1:0] blk_ref_d, blk_ref_q;
    logic [3:0]       blk_mapper_d, blk_mapper_q, blk_device_d, blk_device_q;

    msx_config_record_buf #(.RECORD_BYTES(RECORD_BYTES)) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (start),
        .accept_i    (accept),
        .data_i      (in_data),
        .rec_o       (rec),
        .rec_valid_o (rec_valid),
        .last_byte_o (last_byte)
    );

    assign accept    = in_valid && in_ready;
    assign trunc     = accept && in_last && !last_byte;
    assign is_mirror = (rec.data_id == DATA_MIRROR);
    // count is 1..PAGES whenever EMIT is entered, so count-1 fits in PW.
    assign emit_last = (page_q == PW'(rec.count - 8'd1));

    // Record checks evaluated while in DECODE.
    always_comb begin
        dec_err  = ERR_NONE;
        dec_emit = 1'b0;
        if (rec.typ > CONFIG_CONFIG) begin
            dec_err = ERR_BAD_TYPE;
        end else if (is_table_write(rec.typ)) begin
            // 9-bit sum so start+count cannot wrap past the page limit.
            if (({1'b0, rec.start_page} + {1'b0, rec.count}) > 9'(PAGES)) begin
                dec_err = ERR_RANGE;
            end else if (rec.count != 8'd0) begin
                if (is_mirror ? !have_ref_q
                              : (ref_cnt_q == (REF_W + 1)'(MAX_REFS))) begin
                    dec_err = ERR_TRUNC_REFS;
                end else begin
                    dec_emit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        err_now = ERR_NONE;
        if (!start) begin
            if (state_q == ST_COLLECT && trunc) begin
                err_now = ERR_TRUNC_REFS;
            end else if (state_q == ST_DECODE) begin
                err_now = dec_err;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. start wins from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_COLLECT;
        end else begin
            unique case (state_q)
                ST_COLLECT: begin
                    if (trunc)          state_d = ST_DONE;
                    else if (rec_valid) state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (dec_err != ERR_NONE) state_d = ST_DONE;
                    else if (dec_emit)       state_d = ST_EMIT;
                    else if (last_seen_q)    state_d = ST_DONE;
                    else                     state_d = ST_COLLECT;
                end
                ST_EMIT: begin
                    if (emit_last) state_d = last_seen_q ? ST_DONE : ST_COLLECT;
                end
                default: ;
            endcase
        end
    end

    // FSM: outputs. Write fields are built here and registered below.
    always_comb begin
        in_ready     = (state_q == ST_COLLECT) && !start;
        busy         = (state_q == ST_COLLECT) || (state_q == ST_DECODE) ||
                       (state_q == ST_EMIT);
        blk_we_d     = 1'b0;
        blk_slot_d   = '0;
        blk_sub_d    = '0;
        blk_page_d   = '0;
        blk_ref_d    = '0;
        blk_offset_d = '0;
        blk_mapper_d = '0;
        blk_device_d = '0;
        blk_cart_d   = 1'b0;
        if (state_q == ST_EMIT && !start) begin
            blk_we_d     = 1'b1;
            blk_slot_d   = rec.slot;
            blk_sub_d    = rec.sub;
            blk_page_d   = PW'(rec.start_page) + page_q;
            blk_ref_d    = cur_ref_q;
            blk_offset_d = cur_mirror_q ? '0 : page_q;
            blk_mapper_d = (rec.typ == CONFIG_SLOT_A || rec.typ == CONFIG_SLOT_B)
                           ? MAPPER_AUTO : rec.mapper;
            blk_device_d = rec.device;
            blk_cart_d   = (rec.typ == CONFIG_SLOT_B);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
            expander_q   <= '0;
            msx_typ_q    <= 1'b0;
            ref_cnt_q    <= '0;
            have_ref_q   <= 1'b0;
            cur_ref_q    <= '0;
            cur_mirror_q <= 1'b0;
            last_seen_q  <= 1'b0;
            page_q       <= '0;
        end else if (start) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
            expander_q   <= '0;
            msx_typ_q    <= 1'b0;
            ref_cnt_q    <= '0;
            have_ref_q   <= 1'b0;
            cur_ref_q    <= '0;
            cur_mirror_q <= 1'b0;
            last_seen_q  <= 1'b0;
            page_q       <= '0;
        end else begin
            // First error code is kept; error itself is sticky.
            if (err_now != ERR_NONE) begin
                error_q <= 1'b1;
                if (!error_q) err_code_q <= err_now;
            end
            if (state_d == ST_DONE && state_q != ST_DONE &&
                err_now == ERR_NONE && !error_q) begin
                done_q <= 1'b1;
            end
            if (accept && in_last) last_seen_q <= 1'b1;
            if (state_q == ST_DECODE && dec_err == ERR_NONE) begin
                if (rec.typ == CONFIG_CONFIG) msx_typ_q <= rec.data_id[0];
                if (is_table_write(rec.typ) && rec.sub != 2'd0) begin
                    expander_q[rec.slot] <= 1'b1;
                end
                if (dec_emit) begin
                    page_q       <= '0;
                    cur_mirror_q <= is_mirror;
                    // Mirrors keep cur_ref_q: the last assigned reference.
                    if (!is_mirror) begin
                        cur_ref_q  <= ref_cnt_q[REF_W-1:0];
                        ref_cnt_q  <= ref_cnt_q + (REF_W + 1)'(1);
                        have_ref_q <= 1'b1;
                    end
                end
            end
            if (state_q == ST_EMIT) page_q <= page_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_we_q     <= 1'b0;
            blk_slot_q   <= '0;
            blk_sub_q    <= '0;
            blk_page_q   <= '0;
            blk_ref_q    <= '0;
            blk_offset_q <= '0;
            blk_mapper_q <= '0;
            blk_device_q <= '0;
            blk_cart_q   <= 1'b0;
        end else begin
            blk_we_q     <= blk_we_d;
            blk_slot_q   <= blk_slot_d;
            blk_sub_q    <= blk_sub_d;
            blk_page_q   <= blk_page_d;
            blk_ref_q    <= blk_ref_d;
            blk_offset_q <= blk_offset_d;
            blk_mapper_q <= blk_mapper_d;
            blk_device_q <= blk_device_d;
            blk_cart_q   <= blk_cart_d;
        end
    end

    assign blk_we      = blk_we_q;
    assign blk_slot    = blk_slot_q;
    assign blk_sub     = blk_sub_q;
    assign blk_page    = blk_page_q;
    assign blk_ref     = blk_ref_q;
    assign blk_offset  = blk_offset_q;
    assign blk_mapper  = blk_mapper_q;
    assign blk_device  = blk_device_q;
    assign blk_cart    = blk_cart_q;
    assign expander_en = expander_q;
    assign msx_typ     = msx_typ_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_msx_config_parser.sv
// Directed self-checking bench for msx_config_parser (default parameters:
// 12-byte records, 16 refs, 4 pages).
module tb_msx_config_parser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready, blk_we, blk_cart, msx_typ, busy, done, error;
    logic [1:0] blk_slot, blk_sub, blk_page, blk_offset, err_code;
    logic [3:0] blk_ref, blk_mapper, blk_device, expander_en;

    msx_config_parser dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .blk_we      (blk_we),
        .blk_slot    (blk_slot),
        .blk_sub     (blk_sub),
        .blk_page    (blk_page),
        .blk_ref     (blk_ref),
        .blk_offset  (blk_offset),
        .blk_mapper  (blk_mapper),
        .blk_device  (blk_device),
        .blk_cart    (blk_cart),
        .expander_en (expander_en),
        .msx_typ     (msx_typ),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every output in one vector, for reset checks.
    logic [32:0] all_outs;
    assign all_outs = {in_ready, blk_we, blk_slot, blk_sub, blk_page, blk_ref,
                       blk_offset, blk_mapper, blk_device, blk_cart,
                       expander_en, msx_typ, busy, done, error, err_code};

    int n_cmp = 0;
    int n_mis = 0;

    logic [11:0] wr_q[$];   // {slot, sub, page, ref, offset}
    logic [8:0]  attr_q[$]; // {cart, mapper, device}
    int          first_we_cyc = -1;
    int          acc_cyc = 0;
    logic [7:0]  rec [12];

    always @(negedge clk) begin
        if (reset_n && blk_we) begin
            wr_q.push_back({blk_slot, blk_sub, blk_page, blk_ref, blk_offset});
            attr_q.push_back({blk_cart, blk_mapper, blk_device});
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] wr(input int slot, input int sub,
                                       input int page, input int rf,
                                       input int off);
        return {2'(slot), 2'(sub), 2'(page), 4'(rf), 2'(off)};
    endfunction

    function automatic logic [11:0] get_wr(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 12'hFFF;
    endfunction

    function automatic logic [8:0] get_attr(input int i);
        if (i < attr_q.size()) return attr_q[i];
        return 9'h1FF;
    endfunction

    task automatic set_rec(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b3, input logic [7:0] b4,
                           input logic [7:0] b5, input logic [7:0] b6);
        for (int i = 0; i < 12; i++) rec[i] = 8'h00;
        rec[0] = b0; rec[1] = b1; rec[3] = b3;
        rec[4] = b4; rec[5] = b5; rec[6] = b6;
    endtask

    task automatic clear_wr();
        wr_q.delete();
        attr_q.delete();
        first_we_cyc = -1;
    endtask

    // Called at a negedge; sends rec[0..n-1], in_last on the final byte
    // if requested; returns at the negedge after the final accept.
    task automatic send(input int n, input bit last_flag);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = rec[i];
            in_last  = last_flag && (i == n - 1);
            #1;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 20) check("in_ready_wait", 64'(in_ready), 64'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_wr();
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
        #1;
    endtask

    initial begin
        int guard;
        // Asynchronous reset with no clock edge yet.
        #1 reset_n = 1'b0;
        #1 check("reset_async_outs", 64'(all_outs), 64'(0));
        #20;
        @(posedge clk);
        #1 check("reset_held_outs", 64'(all_outs), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 check("idle_in_ready", 64'(in_ready), 64'(0));

        // Data record then mirror record, last on the second.
        pulse_start();
        #1 check("start_busy_ready", 64'({busy, in_ready}), 64'(2'b11));
        set_rec(8'h4C, 8'h01, 8'h02, 8'h00, 8'h02, 8'h0A);
        send(12, 1'b0);
        settle();
        check("t1a_nwr", 64'(wr_q.size()), 64'(2));
        check("t1a_wr0", 64'(get_wr(0)), 64'(wr(3, 0, 0, 0, 0)));
        check("t1a_wr1", 64'(get_wr(1)), 64'(wr(3, 0, 1, 0, 1)));
        check("t1a_attr0", 64'(get_attr(0)), 64'({1'b0, 4'h2, 4'hA}));
        check("t1a_latency", 64'(first_we_cyc - acc_cyc), 64'(2));
        check("t1a_not_done", 64'({done, busy}), 64'(2'b01));
        clear_wr();
        set_rec(8'h4C, 8'h00, 8'h01, 8'h02, 8'h02, 8'h00);
        send(12, 1'b1);
        settle();
        check("t1b_nwr", 64'(wr_q.size()), 64'(1));
        check("t1b_wr0", 64'(get_wr(0)), 64'(wr(3, 0, 2, 0, 0)));
        check("t1b_status", 64'({done, error, err_code, busy, in_ready}),
              64'(6'b100000));

        // Subslot record sets the expander enable of slot 3.
        pulse_start();
        check("start_clears_done", 64'(done), 64'(0));
        set_rec(8'h4F, 8'h03, 8'h01, 8'h01, 8'h00, 8'h00);
        send(12, 1'b1);
        settle();
        check("t2_nwr", 64'(wr_q.size()), 64'(1));
        check("t2_wr0", 64'(get_wr(0)), 64'(wr(3, 3, 1, 0, 0)));
        check("t2_expander", 64'(expander_en), 64'(4'b1000));
        check("t2_done", 64'(done), 64'(1));

        // Cartridge B: mapper forced to AUTO, cart = 1.
        pulse_start();
        check("start_clears_exp", 64'(expander_en), 64'(0));
        set_rec(8'h3D, 8'h01, 8'h01, 8'h00, 8'h05, 8'h07);
        send(12, 1'b1);
        settle();
        check("t3_wr0", 64'(get_wr(0)), 64'(wr(3, 1, 0, 0, 0)));
        check("t3_attr0", 64'(get_attr(0)), 64'({1'b1, 4'hF, 4'h7}));
        check("t3_expander", 64'(expander_en), 64'(4'b1000));

        // start + count = 5 > 4 pages.
        pulse_start();
        set_rec(8'h4C, 8'h01, 8'h03, 8'h02, 8'h00, 8'h00);
        send(12, 1'b1);
        settle();
        check("t4_nwr", 64'(wr_q.size()), 64'(0));
        check("t4_status", 64'({done, error, err_code}), 64'(4'b0110));

        // Unknown record type 7.
        pulse_start();
        set_rec(8'h70, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        send(12, 1'b1);
        settle();
        check("t5_status", 64'({done, error, err_code}), 64'(4'b0101));

        // Image truncated after 7 bytes.
        pulse_start();
        set_rec(8'h4C, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        send(7, 1'b1);
        settle();
        check("t6_status", 64'({done, error, err_code, in_ready, busy}),
              64'(6'b011100));
        check("t6_nwr", 64'(wr_q.size()), 64'(0));

        // start during EMIT of a count-4 record aborts it.
        pulse_start();
        set_rec(8'h4D, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00);
        send(12, 1'b0);
        guard = 0;
        while (blk_we !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("t7_we_seen", 64'(blk_we), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t7_we_stops", 64'(blk_we), 64'(0));
        check("t7_nwr", 64'(wr_q.size()), 64'(1));
        check("t7_restored", 64'({expander_en, done, error, err_code, msx_typ}),
              64'(0));
        check("t7_collect", 64'({busy, in_ready}), 64'(2'b11));
        settle();
        check("t7_no_more_wr", 64'(wr_q.size()), 64'(1));
        clear_wr();
        set_rec(8'h4C, 8'h01, 8'h01, 8'h03, 8'h00, 8'h00);
        send(12, 1'b1);
        settle();
        check("t7_resume_wr", 64'(get_wr(0)), 64'(wr(3, 0, 3, 0, 0)));
        check("t7_resume_done", 64'(done), 64'(1));

        // CONFIG record sets the MSX type and writes nothing.
        pulse_start();
        set_rec(8'h60, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        send(12, 1'b1);
        settle();
        check("t8_msx_typ", 64'(msx_typ), 64'(1));
        check("t8_nwr", 64'(wr_q.size()), 64'(0));
        check("t8_done", 64'(done), 64'(1));

        // Asynchronous reset mid-record, away from any clock edge.
        pulse_start();
        set_rec(8'h4C, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        send(5, 1'b0);
        #1 check("t9_busy_before", 64'({busy, in_ready}), 64'(2'b11));
        #2 reset_n = 1'b0;
        #1 check("t9_async_outs", 64'(all_outs), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/msx_config_parser.md
Name: msx_config_parser

Overview:
- Streaming parser for the machine-configuration image, consisting of fixed-length records loaded over the download path.
- Collects each record, decodes its type and slot/subslot, and expands it into per-page block-table writes (slot × subslot × page).
- Derives the per-slot expander enables and the MSX type, which feed the slot decoder and the BIOS config.
- Parametrised successor of the fixed 12-byte, 4-slot layout. Adds mirror-reference tracking, range checking and error reporting.

Parameters:
- RECORD_BYTES, 12, bytes per record; must be ≥ 8.
- MAX_REFS, 16, maximum number of data-bearing (non-mirror) records. ref_ram width is REF_W = $clog2(MAX_REFS).
- PAGES, 4, pages per subslot (16 KB each). Page index width PW = $clog2(PAGES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears state and begins a parse
- in_valid  in  1  byte strobe
- in_data  in  8  config byte
- in_last  in  1  final byte of the image, qualified by in_valid
- in_ready  out  1  parser accepts the byte this cycle
- blk_we  out  1  block-table write strobe
- blk_slot  out  2  target slot
- blk_sub  out  2  target subslot
- blk_page  out  PW  target page
- blk_ref  out  REF_W  data reference (ref_ram)
- blk_offset  out  PW  block offset within the referenced data
- blk_mapper  out  4  mapper_typ_t
- blk_device  out  4  device_typ_t
- blk_cart  out  1  cart number (0 = A, 1 = B)
- expander_en  out  4  per-slot expander enable
- msx_typ  out  1  MSX_typ_t
- busy  out  1  parse in progress
- done  out  1  sticky; set on successful end of parse
- error  out  1  sticky error flag
- err_code  out  2  0 none, 1 bad type, 2 range, 3 truncated / too many refs

Behaviour:
- Reset: every output is 0; state = IDLE; the reference counter is 0.
- start: valid in any state. Clears done, error, err_code, expander_en, msx_typ and the reference counter, then moves to COLLECT.
- start while mid-operation: aborts the current record with no further blk_we.
- IDLE: in_ready = 0.
- COLLECT:
  - in_ready = 1; each accepted byte is stored at index byte_cnt, and byte_cnt increments.
  - At byte_cnt == RECORD_BYTES-1 with an accept, go to DECODE.
  - in_last accepted with byte_cnt == RECORD_BYTES-1: decode this record, then finish (DONE).
  - in_last accepted at any other byte_cnt: set err 3 and go to DONE.
- Record fields:
  - b0[7:4] = config_typ_t; b0[3:2] = slot; b0[1:0] = subslot.
  - b1 = data_ID_t (0 means mirror).
  - b3 = count; b4 = start page.
  - b5 = mapper (low 4 bits); b6 = device (low 4 bits).
  - Bytes b7 and above are ignored.
- DECODE (1 cycle), in_ready = 0. Action by type:
  - CONFIG_CONFIG: msx_typ <= b1[0].
  - CONFIG_KBD_LAYOUT, CONFIG_FDC: no table write.
  - CONFIG_SLOT_A / CONFIG_SLOT_B: blk_cart = 0 / 1; mapper = MAPPER_AUTO.
  - CONFIG_SLOT_INTERNAL: table write using b5 / b6.
  - CONFIG_NONE: ignored, with no error.
  - Any other type: err 1, go to DONE.
- Range and reference rules (checked in DECODE):
  - start + count > PAGES (compute with 9-bit width, so there is no wrap) → err 2, go to DONE.
  - count == 0 → no writes; return to COLLECT.
  - b1 != 0 (data record): the record is assigned cur_ref = ref counter, then the counter increments. If the counter is already at MAX_REFS → err 3.
  - b1 == 0 (mirror): reuses the last assigned ref. A mirror with no prior data record → err 3.
  - Any slot/internal record with subslot != 0 sets expander_en[slot].
- EMIT: one blk_we per cycle for p = 0..count-1, with:
  - blk_page = start+p
  - blk_offset = p for data records, 0 for mirrors
  - blk_ref = cur_ref
  - in_ready = 0 throughout.
  - After the last write: return to COLLECT, or go to DONE if in_last was already seen.
- Write timing: each blk_* field is registered and valid only while blk_we = 1. Latency from the record's last byte accepted to the first blk_we is exactly 2 cycles.
- DONE: busy = 0. done = 1 only when error = 0; error is sticky. Stays in DONE until start.
- in_valid while in_ready = 0: the byte is not consumed; the source must hold it.

Decomposition:
- Add to the shared MSX package:
  - config_record_t (decoded b0..b6 fields)
  - parser_err_t enum
- Reuse the existing config_typ_t, mapper_typ_t, device_typ_t and data_ID_t.
- One sub-module: msx_config_record_buf. It holds the RECORD_BYTES byte collector and counter and outputs a packed config_record_t plus a rec_valid strobe.

Test Plan:
- Two records: [4C 01 00 02 00 02 0A ..] then [4C 00 00 01 02 02 ..], last on the final byte → first record gives writes (3,0,p0/ref0/off0) and (3,0,p1/ref0/off1); second gives (3,0,p2/ref0/off0); done = 1.
- Record 4F 03 00 01 01 .. → one write at slot 3, sub 3, page 1; expander_en = 4'b1000.
- Record 4C 01 00 03 02 .. → start+count = 5 > 4 → error = 1, err_code = 2, no blk_we.
- Stream ends after 7 bytes → err_code = 3, done = 0, in_ready = 0.
- Pulse start during EMIT of a count-4 record → blk_we stops the next cycle; reset values are restored; COLLECT resumes.
- Record 60 01 .. → msx_typ = 1 and no writes. Also check: reset_n asserted asynchronously mid-record → all outputs 0 without a clock edge.
